sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one SRAM-like memory port between the IF-stage instruction requester and the EXE/MEM-stage data requester of the 5-stage pipeline.
- Accepts one request at a time and sequences it on the shared port: address phase, then response phase.
- Routes the response back to the requester that owns the transaction.
- Data has priority over instructions; a starvation counter guarantees instruction fetch progress.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_LIMIT, 3, consecutive data grants with inst_req pending before inst is forced; must be >=1

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
inst_req  input  1  instruction read request
inst_addr  input  ADDR_W  instruction address
inst_addr_ok  output  1  request accepted (latched) this cycle
inst_data_ok  output  1  instruction read data valid this cycle
inst_rdata  output  DATA_W  read data, equals mem_rdata
data_req  input  1  data request
data_wr  input  1  1=store, 0=load
data_wstrb  input  4  byte write strobes (stores)
data_addr  input  ADDR_W  data address
data_wdata  input  DATA_W  store data
data_addr_ok  output  1  request accepted (latched) this cycle
data_data_ok  output  1  load data valid / store complete this cycle
data_rdata  output  DATA_W  read data, equals mem_rdata
mem_req  output  1  shared-port request
mem_wr  output  1  shared-port write flag
mem_wstrb  output  4  shared-port strobes
mem_addr  output  ADDR_W  shared-port address
mem_wdata  output  DATA_W  shared-port write data
mem_addr_ok  input  1  memory accepted address this cycle
mem_data_ok  input  1  memory response this cycle
mem_rdata  input  DATA_W  memory read data

Behaviour:
- Clock is clk; reset is asynchronous and active-high. On reset: state IDLE, owner=none, starve_cnt=0, latched request fields (wr, wstrb, addr, wdata) = 0, so mem_* outputs are 0. All *_addr_ok, *_data_ok and mem_req are 0.
- FSM states: IDLE, ADDR, RESP.
- IDLE:
  - Grant is combinational: inst if inst_req && (!data_req || starve_cnt==STARVE_LIMIT); otherwise data if data_req.
  - The winner's *_addr_ok=1 in the same cycle.
  - The arbiter latches the winner's fields and owner, then moves to ADDR.
  - An inst grant latches wr=0 and wstrb=0.
  - With no request, the FSM stays in IDLE.
- ADDR:
  - mem_req=1, driven from the latched fields, which stay stable while mem_req=1.
  - On mem_addr_ok: move to RESP. Otherwise hold.
- RESP:
  - mem_req=0.
  - On mem_data_ok: the owner's *_data_ok=1 combinationally in the same cycle, then move to IDLE.
  - The non-owner's *_data_ok stays 0.
- inst_rdata and data_rdata are both wired directly to mem_rdata.
- mem_data_ok in IDLE or ADDR, and mem_addr_ok outside ADDR, are ignored.
- No new grant is made outside IDLE. *_addr_ok stays 0 in ADDR and RESP, even with requests pending.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on a data grant while inst_req=1.
  - Clears to 0 on any inst grant.
  - Otherwise holds.
- Latency: addr_ok at cycle 0, mem_req at cycle 1. With an immediate mem_addr_ok, RESP is entered at cycle 2, and the earliest data_ok is at cycle 2. Minimum occupancy is 3 cycles per transaction.
- Reset mid-transaction: everything returns to the reset state at once. The in-flight response is dropped and no *_data_ok is produced for it.

Test Plan:
- Inst read: inst_req=1, inst_addr=0xBFC00000; mem_addr_ok=1 at cycle 1; mem_data_ok=1 with mem_rdata=0x24010001 at cycle 3 -> inst_addr_ok=1 at cycle 0; mem_req=1, mem_addr=0xBFC00000, mem_wr=0 at cycle 1; inst_data_ok=1 with inst_rdata=0x24010001 at cycle 3; data_data_ok=0 throughout.
- Store: data_req=1, data_wr=1, wstrb=4'b0011, addr=0x00001000, wdata=0xDEADBEEF -> mem_wr=1, mem_wstrb=4'b0011, mem_addr=0x1000, mem_wdata=0xDEADBEEF; data_data_ok=1 in the mem_data_ok cycle.
- Simultaneous inst_req and data_req in IDLE with starve_cnt=0 -> data_addr_ok=1, inst_addr_ok=0; inst is granted in the first IDLE cycle after the data response.
- Starvation, STARVE_LIMIT=2: data_req and inst_req held high, memory always ready -> grant order D,D,I,D,D,I.
- Address stall: mem_addr_ok held low for 5 cycles -> mem_req=1 with stable mem_addr/mem_wdata for all 5 cycles; no additional *_addr_ok.
- Reset asserted in RESP, then mem_data_ok=1 after deassertion -> all outputs 0 immediately on reset; no *_data_ok; FSM is in IDLE.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one SRAM-like port between instruction and data requesters
// One transaction in flight: IDLE grants, ADDR presents the request, RESP waits for the response.
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

  state_t            state, state_d;
  owner_t            owner;
  logic [CNT_W-1:0]  starve_cnt;
  logic              lat_wr;
  logic [3:0]        lat_wstrb;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              starve_hit;
  logic              grant_inst;
  logic              grant_data;

  // Data wins unless the instruction side has been passed over STARVE_LIMIT times in a row.
  assign starve_hit = (starve_cnt == CNT_MAX);
  assign grant_inst = !reset && (state == IDLE) && inst_req && (!data_req || starve_hit);
  assign grant_data = !reset && (state == IDLE) && data_req && !grant_inst;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
  assign mem_wr     = lat_wr;
  assign mem_wstrb  = lat_wstrb;
  assign mem_addr   = lat_addr;
  assign mem_wdata  = lat_wdata;

  always_comb begin
    state_d      = state;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    mem_req      = 1'b0;
    case (state)
      IDLE: begin
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        if (grant_inst || grant_data) state_d = ADDR;
      end
      ADDR: begin
        mem_req = 1'b1;
        if (mem_addr_ok) state_d = RESP;
      end
      RESP: begin
        if (mem_data_ok) begin
          inst_data_ok = (owner == OWN_INST);
          data_data_ok = (owner == OWN_DATA);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      starve_cnt <= '0;
      lat_wr     <= 1'b0;
      lat_wstrb  <= 4'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      state <= state_d;
      if (grant_inst) begin
        owner      <= OWN_INST;
        lat_wr     <= 1'b0;
        lat_wstrb  <= 4'b0;
        lat_addr   <= inst_addr;
        lat_wdata  <= '0;
        starve_cnt <= '0;
      end else if (grant_data) begin
        owner     <= OWN_DATA;
        lat_wr    <= data_wr;
        lat_wstrb <= data_wstrb;
        lat_addr  <= data_addr;
        lat_wdata <= data_wdata;
        if (inst_req && !starve_hit) starve_cnt <= starve_cnt + CNT_W'(1);
      end else if (state == RESP && mem_data_ok) begin
        owner <= OWN_NONE;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter
module tb_sram_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 2;

  logic          clk, reset;
  logic          inst_req, inst_addr_ok, inst_data_ok;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]    data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0]    mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  typedef struct packed {
    logic          is_inst;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  // Every response is matched against the oldest outstanding grant.
  always @(negedge clk) begin
    if (!reset && (inst_data_ok || data_data_ok)) begin
      total++;
      if (inst_data_ok && data_data_ok) begin
        bad++;
        $display("FAIL both_data_ok got=11 want=one_hot");
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_data_ok got inst=%0b data=%0b want none", inst_data_ok, data_data_ok);
      end else begin
        mon_e = sb.pop_front();
        if (inst_data_ok !== mon_e.is_inst) begin
          bad++;
          $display("FAIL resp_owner got inst=%0b want inst=%0b", inst_data_ok, mon_e.is_inst);
        end else if ((mon_e.is_inst ? inst_rdata : data_rdata) !== mon_e.rdata) begin
          bad++;
          $display("FAIL resp_rdata got=%08h want=%08h",
                   mon_e.is_inst ? inst_rdata : data_rdata, mon_e.rdata);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    inst_req = 1'b1; data_req = 1'b1;
    step(); look();
    total++;
    if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%05b want=00000",
               {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
    end
    total++;
    if ({mem_wr, mem_wstrb, mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_fields got wr=%0b strb=%h addr=%h wdata=%h want all 0",
               mem_wr, mem_wstrb, mem_addr, mem_wdata);
    end
    inst_req = 1'b0; data_req = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_inst_read();
    step();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    look();
    total++;
    if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
      bad++;
      $display("FAIL inst_grant got i=%0b d=%0b want i=1 d=0", inst_addr_ok, data_addr_ok);
    end
    sb.push_back({1'b1, 32'h2401_0001});
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b1;
    look();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0_0000 || mem_wr !== 1'b0) begin
      bad++;
      $display("FAIL inst_addr_phase got req=%0b addr=%h wr=%0b want 1 bfc00000 0",
               mem_req, mem_addr, mem_wr);
    end
    step();
    mem_addr_ok = 1'b0;
    look();
    total++;
    if (mem_req !== 1'b0 || inst_data_ok !== 1'b0) begin
      bad++;
      $display("FAIL inst_resp_wait got req=%0b dok=%0b want 0 0", mem_req, inst_data_ok);
    end
    step();
    mem_data_ok = 1'b1; mem_rdata = 32'h2401_0001;
    look();
    total++;
    if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h2401_0001) begin
      bad++;
      $display("FAIL inst_data got ok=%0b rdata=%h want 1 24010001", inst_data_ok, inst_rdata);
    end
    step();
    mem_data_ok = 1'b0;
  endtask

  task automatic test_store();
    step();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_addr = 32'h0000_1000; data_wdata = 32'hDEAD_BEEF;
    look();
    total++;
    if (data_addr_ok !== 1'b1) begin
      bad++;
      $display("FAIL store_grant got=%0b want=1", data_addr_ok);
    end
    sb.push_back({1'b0, 32'h0000_0000});
    step();
    data_req = 1'b0; mem_addr_ok = 1'b1;
    look();
    total++;
    if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_wstrb !== 4'b0011 ||
        mem_addr !== 32'h0000_1000 || mem_wdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL store_fields got req=%0b wr=%0b strb=%b addr=%h wdata=%h want 1 1 0011 00001000 deadbeef",
               mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata);
    end
    step();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0;
    look();
    total++;
    if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin
      bad++;
      $display("FAIL store_done got d=%0b i=%0b want d=1 i=0", data_data_ok, inst_data_ok);
    end
    step();
    mem_data_ok = 1'b0;
  endtask

  task automatic test_priority();
    step();
    inst_req = 1'b1; inst_addr = 32'h0000_0200;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0300;
    look();
    total++;
    if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
      bad++;
      $display("FAIL prio_grant got d=%0b i=%0b want d=1 i=0", data_addr_ok, inst_addr_ok);
    end
    sb.push_back({1'b0, 32'hA5A5_0003});
    step();
    data_req = 1'b0; mem_addr_ok = 1'b1;
    look();
    total++;
    if (inst_addr_ok !== 1'b0) begin
      bad++;
      $display("FAIL prio_no_grant_addr got=%0b want=0", inst_addr_ok);
    end
    step();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hA5A5_0003;
    look();
    total++;
    if (inst_addr_ok !== 1'b0) begin
      bad++;
      $display("FAIL prio_no_grant_resp got=%0b want=0", inst_addr_ok);
    end
    step();
    mem_data_ok = 1'b0;
    look();
    total++;
    if (inst_addr_ok !== 1'b1) begin
      bad++;
      $display("FAIL prio_inst_next got=%0b want=1", inst_addr_ok);
    end
    sb.push_back({1'b1, 32'hA5A5_0002});
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hA5A5_0002;
    step();
    mem_data_ok = 1'b0;
  endtask

  task automatic test_starvation();
    logic [5:0] order;
    int n, cycles;
    order = 6'b100100;
    n = 0; cycles = 0;
    step();
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_3000;
    inst_req = 1'b1; inst_addr = 32'h0000_0400;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h5A5A_0001;
    while (n < 6 && cycles < 60) begin
      look();
      if (inst_addr_ok || data_addr_ok) begin
        total++;
        if (inst_addr_ok !== order[n] || (inst_addr_ok && data_addr_ok)) begin
          bad++;
          $display("FAIL starve_order_%0d got i=%0b d=%0b want inst=%0b", n, inst_addr_ok, data_addr_ok, order[n]);
        end
        sb.push_back({inst_addr_ok, 32'h5A5A_0001});
        n++;
      end
      cycles++;
      if (n < 6) step();
    end
    total++;
    if (n != 6) begin
      bad++;
      $display("FAIL starve_timeout got grants=%0d want=6", n);
    end
    step();
    data_req = 1'b0; inst_req = 1'b0;
    repeat (3) step();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
  endtask

  task automatic test_addr_stall();
    step();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b1111;
    data_addr = 32'h0000_2000; data_wdata = 32'h1234_5678; inst_req = 1'b1;
    look();
    total++;
    if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
      bad++;
      $display("FAIL stall_grant got d=%0b i=%0b want d=1 i=0", data_addr_ok, inst_addr_ok);
    end
    sb.push_back({1'b0, 32'hCAFE_0000});
    step();
    data_req = 1'b0; data_addr = 32'hFFFF_FFFF; data_wdata = 32'h0;
    for (int k = 0; k < 5; k++) begin
      look();
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_2000 || mem_wdata !== 32'h1234_5678 ||
          inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
        bad++;
        $display("FAIL stall_cycle_%0d got req=%0b addr=%h wdata=%h aok=%0b%0b want 1 00002000 12345678 00",
                 k, mem_req, mem_addr, mem_wdata, inst_addr_ok, data_addr_ok);
      end
      step();
    end
    mem_addr_ok = 1'b1; inst_req = 1'b0;
    step();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_0000;
    look();
    total++;
    if (data_data_ok !== 1'b1) begin
      bad++;
      $display("FAIL stall_done got=%0b want=1", data_data_ok);
    end
    step();
    mem_data_ok = 1'b0;
  endtask

  task automatic test_reset_mid();
    step();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
    look();
    sb.push_back({1'b1, 32'h0});
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0;
    step();
    reset = 1'b1;
    sb.delete();
    #1;
    total++;
    if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0 ||
        {mem_wr, mem_wstrb, mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got req=%0b addr=%h wdata=%h want all 0", mem_req, mem_addr, mem_wdata);
    end
    step();
    reset = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_0000;
    look();
    total++;
    if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
      bad++;
      $display("FAIL midreset_dropped got i=%0b d=%0b want 0 0", inst_data_ok, data_data_ok);
    end
    step();
    mem_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'h0000_0100;
    look();
    total++;
    if (inst_addr_ok !== 1'b1) begin
      bad++;
      $display("FAIL midreset_idle got=%0b want=1", inst_addr_ok);
    end
    sb.push_back({1'b1, 32'h1111_2222});
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b1;
    look();
    total++;
    if (mem_addr !== 32'h0000_0100) begin
      bad++;
      $display("FAIL midreset_addr got=%h want=00000100", mem_addr);
    end
    step();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    mem_data_ok = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'b0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    test_reset();
    test_inst_read();
    test_store();
    test_priority();
    test_starvation();
    test_addr_stall();
    test_reset_mid();
    repeat (2) step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL outstanding_responses got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
